// File: rtl/load_store_unit.sv
// RV32I memory stage: byte/half/word loads and stores against an internal
// little-endian byte-addressed RAM, splitting word-crossing accesses in two.
module load_store_unit #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [2:0]           funct3,
    input  logic [DATAWIDTH-1:0] addr,
    input  logic [DATAWIDTH-1:0] store_data,
    output logic                 resp_valid,
    output logic [DATAWIDTH-1:0] load_data,
    output logic                 resp_err,
    output logic                 stall
);

    localparam int WIDXW  = ADDRWIDTH - 2;
    localparam int NWORDS = 32'd1 << WIDXW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [WIDXW-1:0]       widx_r;
    logic [1:0]             off_r;
    logic [2:0]             funct3_r;
    logic [DATAWIDTH-1:0]   sdata_r;
    logic                   is_store_r;
    logic [DATAWIDTH-1:0]   lo_word_r;

    logic                   resp_valid_r;
    logic [DATAWIDTH-1:0]   load_data_r;
    logic                   resp_err_r;
    logic                   req_ready_r;
    logic                   stall_r;

    logic                   legal_load_s;
    logic                   legal_store_s;
    logic                   illegal_s;
    logic                   accept_s;
    logic [2:0]             size_s;
    logic [3:0]             size_mask_s;
    logic                   cross_s;
    logic [7:0]             be_win_s;
    logic [2*DATAWIDTH-1:0] wdata_win_s;
    logic [2*DATAWIDTH-1:0] rdata_win_s;
    logic [2*DATAWIDTH-1:0] rshift_s;
    logic [WIDXW-1:0]       acc_idx_s;
    logic [3:0]             mem_be_s;
    logic [DATAWIDTH-1:0]   mem_wdata_s;
    logic                   mem_we_s;
    logic [DATAWIDTH-1:0]   mem_rdata_s;
    logic [DATAWIDTH-1:0]   ext_s;
    logic                   unused_s;

    logic [DATAWIDTH-1:0]   mem [NWORDS];

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign load_data  = load_data_r;
    assign resp_err   = resp_err_r;
    assign stall      = stall_r;

    // Upper address bits and the spill half of the read window are don't-care.
    assign unused_s = ^{addr[DATAWIDTH-1:ADDRWIDTH], rshift_s[2*DATAWIDTH-1:DATAWIDTH]};

    // Classify the incoming request as legal load, legal store or illegal.
    always_comb begin
        legal_load_s  = 1'b0;
        legal_store_s = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: begin
                legal_load_s  = MemRead & ~MemWrite;
                legal_store_s = MemWrite & ~MemRead;
            end
            3'b100, 3'b101: begin
                legal_load_s  = MemRead & ~MemWrite;
                legal_store_s = 1'b0;
            end
            default: begin
                legal_load_s  = 1'b0;
                legal_store_s = 1'b0;
            end
        endcase
        illegal_s = ~(legal_load_s | legal_store_s);
        accept_s  = req_valid & (state_r == IDLE);
    end

    // Access geometry: size, crossing flag and the two-word byte-lane window.
    always_comb begin
        size_s      = 3'd4;
        size_mask_s = 4'b1111;
        case (funct3_r[1:0])
            2'b00: begin
                size_s      = 3'd1;
                size_mask_s = 4'b0001;
            end
            2'b01: begin
                size_s      = 3'd2;
                size_mask_s = 4'b0011;
            end
            default: begin
                size_s      = 3'd4;
                size_mask_s = 4'b1111;
            end
        endcase
        cross_s     = (({1'b0, off_r} + size_s) > 3'd4);
        be_win_s    = {4'b0000, size_mask_s} << off_r;
        wdata_win_s = {{DATAWIDTH{1'b0}}, sdata_r} << {off_r, 3'b000};
    end

    // RAM port: ACC1 targets word W (low lanes), ACC2 word W+1 (high lanes).
    always_comb begin
        if (state_r == ACC2) begin
            acc_idx_s   = widx_r + WIDXW'(1'b1);
            mem_be_s    = be_win_s[7:4];
            mem_wdata_s = wdata_win_s[2*DATAWIDTH-1:DATAWIDTH];
        end else begin
            acc_idx_s   = widx_r;
            mem_be_s    = be_win_s[3:0];
            mem_wdata_s = wdata_win_s[DATAWIDTH-1:0];
        end
        mem_we_s    = is_store_r & ~rst & ((state_r == ACC1) | (state_r == ACC2));
        mem_rdata_s = mem[acc_idx_s];
    end

    // Assemble the addressed bytes and apply sign or zero extension.
    always_comb begin
        if (state_r == ACC2) begin
            rdata_win_s = {mem_rdata_s, lo_word_r};
        end else begin
            rdata_win_s = {{DATAWIDTH{1'b0}}, mem_rdata_s};
        end
        rshift_s = rdata_win_s >> {off_r, 3'b000};
        case (funct3_r)
            3'b000:  ext_s = {{(DATAWIDTH-8){rshift_s[7]}}, rshift_s[7:0]};
            3'b001:  ext_s = {{(DATAWIDTH-16){rshift_s[15]}}, rshift_s[15:0]};
            3'b100:  ext_s = {{(DATAWIDTH-8){1'b0}}, rshift_s[7:0]};
            3'b101:  ext_s = {{(DATAWIDTH-16){1'b0}}, rshift_s[15:0]};
            default: ext_s = rshift_s[DATAWIDTH-1:0];
        endcase
    end

    // Next-state logic; illegal requests skip the RAM entirely.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (illegal_s) begin
                        state_nxt_s = RESP;
                    end else begin
                        state_nxt_s = ACC1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACC1: begin
                if (cross_s) begin
                    state_nxt_s = ACC2;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            ACC2:    state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture on accept, plus the low word of a split load.
    always_ff @(posedge clk) begin
        if (rst) begin
            widx_r     <= '0;
            off_r      <= 2'b00;
            funct3_r   <= 3'b000;
            sdata_r    <= '0;
            is_store_r <= 1'b0;
            lo_word_r  <= '0;
        end else begin
            if (accept_s) begin
                widx_r     <= addr[ADDRWIDTH-1:2];
                off_r      <= addr[1:0];
                funct3_r   <= funct3;
                sdata_r    <= store_data;
                is_store_r <= legal_store_s;
            end
            if (state_r == ACC1) begin
                lo_word_r <= mem_rdata_s;
            end
        end
    end

    // Registered handshake and response outputs; data holds outside RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            load_data_r  <= '0;
            resp_err_r   <= 1'b0;
            req_ready_r  <= 1'b1;
            stall_r      <= 1'b0;
        end else begin
            resp_valid_r <= (state_nxt_s == RESP);
            req_ready_r  <= (state_nxt_s == IDLE);
            stall_r      <= (state_nxt_s != IDLE);
            if (accept_s && illegal_s) begin
                load_data_r <= '0;
                resp_err_r  <= 1'b1;
            end else if (((state_r == ACC1) && !cross_s) || (state_r == ACC2)) begin
                load_data_r <= is_store_r ? '0 : ext_s;
                resp_err_r  <= 1'b0;
            end
        end
    end

    // Byte-enabled RAM write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            if (mem_be_s[0]) mem[acc_idx_s][7:0]   <= mem_wdata_s[7:0];
            if (mem_be_s[1]) mem[acc_idx_s][15:8]  <= mem_wdata_s[15:8];
            if (mem_be_s[2]) mem[acc_idx_s][23:16] <= mem_wdata_s[23:16];
            if (mem_be_s[3]) mem[acc_idx_s][31:24] <= mem_wdata_s[31:24];
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and random requests
// compared against a byte-array reference model of the memory stage.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        resp_err;
    logic        stall;

    int vectors = 0;
    int miscompares = 0;

    bit [7:0] ref_mem [0:131071];
    bit       known   [0:131071];

    always #5 clk = ~clk;

    load_store_unit #(.DATAWIDTH(32), .ADDRWIDTH(17)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3), .addr(addr),
        .store_data(store_data), .resp_valid(resp_valid), .load_data(load_data),
        .resp_err(resp_err), .stall(stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RV32I semantics over a flat 128 KiB byte array.
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output int lat, output logic [31:0] ld,
                                  output logic er, output bit ok);
        int size;
        int base;
        bit legal;
        logic [31:0] val;
        legal = 0;
        if (rd && !wr) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (wr && !rd) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ok = 1;
        if (!legal) begin
            lat = 1; ld = 32'h0; er = 1'b1;
            return;
        end
        er = 1'b0;
        base = int'(a % 32'd131072);
        lat = ((base % 4) + size > 4) ? 3 : 2;
        val = 32'h0;
        for (int k = 0; k < size; k++) begin
            if (wr) begin
                ref_mem[(base + k) % 131072] = d[8*k +: 8];
                known[(base + k) % 131072] = 1;
            end else begin
                val = val | (32'(ref_mem[(base + k) % 131072]) << (8 * k));
                if (!known[(base + k) % 131072]) ok = 0;
            end
        end
        if (wr) begin
            ld = 32'h0;
        end else begin
            if (f3 == 3'd0 && val[7])  val = val | 32'hFFFFFF00;
            if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF0000;
            ld = val;
        end
    endfunction

    task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] ld, output logic er);
        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; store_data = d;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        lat = 1;
        check("stall_busy", {31'b0, stall}, 32'd1);
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            check("stall_busy", {31'b0, stall}, 32'd1);
        end
        ld = load_data;
        er = resp_err;
        @(posedge clk); #1;
        check("resp_pulse", {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, output logic [31:0] ld);
        int exp_lat;
        int lat;
        logic [31:0] exp_ld;
        logic exp_er;
        logic er;
        bit ok;
        model(rd, wr, f3, a, d, exp_lat, exp_ld, exp_er, ok);
        do_req(rd, wr, f3, a, d, lat, ld, er);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, {31'b0, er}, {31'b0, exp_er});
        if (ok) check({tag, "_data"}, ld, exp_ld);
    endtask

    initial begin
        logic [31:0] ld;
        int kind;
        logic rd;
        logic wr;
        logic [2:0] f3;
        logic [31:0] a;

        rst = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("sw100", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, ld);
        run("lw100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, ld);
        check("lw100_const", ld, 32'hDEADBEEF);

        run("sw100b", 1'b0, 1'b1, 3'b010, 32'h100, 32'h80FF7F01, ld);
        run("lb103", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, ld);
        check("lb103_const", ld, 32'hFFFFFF80);
        run("lbu103", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, ld);
        check("lbu103_const", ld, 32'h00000080);
        run("lh102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, ld);
        check("lh102_const", ld, 32'hFFFF80FF);
        run("lhu100", 1'b1, 1'b0, 3'b101, 32'h100, 32'h0, ld);
        check("lhu100_const", ld, 32'h00007F01);

        run("sw200", 1'b0, 1'b1, 3'b010, 32'h200, 32'hA0A1A2A3, ld);
        run("sw204", 1'b0, 1'b1, 3'b010, 32'h204, 32'hB0B1B2B3, ld);
        run("sw201x", 1'b0, 1'b1, 3'b010, 32'h201, 32'h11223344, ld);
        run("lw200", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, ld);
        check("lw200_const", ld, 32'h223344A3);
        run("lw204", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, ld);
        check("lw204_const", ld, 32'hB0B1B211);
        run("lw201x", 1'b1, 1'b0, 3'b010, 32'h201, 32'h0, ld);
        check("lw201_const", ld, 32'h11223344);

        run("sw_top", 1'b0, 1'b1, 3'b010, 32'h1FFFC, 32'h12345678, ld);
        run("sw_zero", 1'b0, 1'b1, 3'b010, 32'h0, 32'h9ABCDEF0, ld);
        run("sh_wrap", 1'b0, 1'b1, 3'b001, 32'h1FFFF, 32'h0000ABCD, ld);
        run("lw_top", 1'b1, 1'b0, 3'b010, 32'h1FFFC, 32'h0, ld);
        check("lw_top_const", ld, 32'hCD345678);
        run("lw_zero", 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, ld);
        check("lw_zero_const", ld, 32'h9ABCDEAB);
        run("lhu_wrap", 1'b1, 1'b0, 3'b101, 32'h1FFFF, 32'h0, ld);
        check("lhu_wrap_const", ld, 32'h0000ABCD);
        run("lw_hibits", 1'b1, 1'b0, 3'b010, 32'hFFFE0100, 32'h0, ld);
        check("lw_hibits_const", ld, 32'h80FF7F01);

        run("ill_lf3", 1'b1, 1'b0, 3'b011, 32'h100, 32'h0, ld);
        check("ill_lf3_zero", ld, 32'h0);
        run("ill_both", 1'b1, 1'b1, 3'b010, 32'h100, 32'h12345678, ld);
        run("ill_none", 1'b0, 1'b0, 3'b000, 32'h100, 32'h12345678, ld);
        run("ill_sf3", 1'b0, 1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, ld);
        run("lw100_kept", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, ld);
        check("lw100_kept_const", ld, 32'h80FF7F01);

        for (int w = 0; w <= 16; w++) begin
            run("init", 1'b0, 1'b1, 3'b010, 32'h300 + 32'(4 * w), $urandom, ld);
        end
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 9));
            rd = (kind == 0) || (kind >= 2 && kind <= 5);
            wr = (kind == 0) || (kind >= 6);
            f3 = 3'($urandom_range(0, 7));
            a = ($urandom & 32'hFFFE0000) | (32'h300 + 32'($urandom_range(0, 63)));
            run("rnd", rd, wr, f3, a, $urandom, ld);
        end
        for (int w = 0; w <= 16; w++) begin
            run("readback", 1'b1, 1'b0, 3'b010, 32'h300 + 32'(4 * w), 32'h0, ld);
        end

        run("sw400", 1'b0, 1'b1, 3'b010, 32'h400, 32'h01020304, ld);
        run("sw404", 1'b0, 1'b1, 3'b010, 32'h404, 32'h05060708, ld);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'b010; addr = 32'h401;
        store_data = 32'h11223344; req_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_acc1_stall", {31'b0, stall}, 32'd1);
        MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h400;
        @(posedge clk); #1;
        check("rst_acc2_stall", {31'b0, stall}, 32'd1);
        check("rst_acc2_noresp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_noresp", {31'b0, resp_valid}, 32'd0);
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; MemRead = 1'b0;
        check("held_accept_stall", {31'b0, stall}, 32'd1);
        check("held_accept_noresp", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("held_resp_valid", {31'b0, resp_valid}, 32'd1);
        check("held_resp_data", load_data, 32'h22334404);
        check("held_resp_err", {31'b0, resp_err}, 32'd0);
        @(posedge clk); #1;
        ref_mem[32'h401] = 8'h44;
        ref_mem[32'h402] = 8'h33;
        ref_mem[32'h403] = 8'h22;
        run("rst_lw400", 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, ld);
        run("rst_lw404", 1'b1, 1'b0, 3'b010, 32'h404, 32'h0, ld);
        check("rst_lw404_const", ld, 32'h05060708);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the register-file/ALU datapath block.
- Consumes the ALU result as a byte address and the second register operand as store data.
- Performs RV32I loads and stores (byte, half, word; signed and unsigned loads) against an internal byte-addressed data RAM, then returns the extended load value for register write-back.
- A multi-cycle FSM with a valid/ready handshake splits word-boundary-crossing accesses into two RAM cycles and stalls upstream meanwhile.

Parameters:
- DATAWIDTH, 32, data and address width.
- ADDRWIDTH, 17, byte-address bits used; RAM holds 2^ADDRWIDTH bytes as 2^(ADDRWIDTH-2) words.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  unit can accept a request.
- MemRead  input  1  request is a load.
- MemWrite  input  1  request is a store.
- funct3  input  3  access width/sign, RV32I encoding.
- addr  input  DATAWIDTH  byte address (ALU result).
- store_data  input  DATAWIDTH  store operand (second register read).
- resp_valid  output  1  one-cycle pulse: request complete.
- load_data  output  DATAWIDTH  extended load result, valid with resp_valid.
- resp_err  output  1  illegal request flag, valid with resp_valid.
- stall  output  1  high whenever a request is in flight (state not IDLE).

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - resp_valid=0, load_data=0, resp_err=0, req_ready=1, stall=0.
  - RAM contents are not reset.
- States: IDLE, ACC1, ACC2, RESP.
- IDLE:
  - req_ready=1.
  - Request accepted on the edge where req_valid&&req_ready.
  - addr, funct3, store_data and type are captured; next state ACC1.
  - req_valid low: stay in IDLE.
- Request decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal: both MemRead and MemWrite high, neither high, load funct3 011/110/111, store funct3 other than 000/001/010.
  - Illegal request: no RAM access; goes IDLE→RESP directly with resp_err=1, load_data=0.
- Address:
  - Bits above ADDRWIDTH-1 ignored.
  - Word index = addr[ADDRWIDTH-1:2]; byte offset = addr[1:0].
  - Little-endian.
- Crossing: an access crosses when offset + size > 4 (LH/SH at offset 3; LW/SW at offsets 1-3).
- ACC1:
  - Accesses word index W.
  - Store: writes the low portion with per-byte enables at the edge leaving ACC1.
  - Load: synchronous read captured at the same edge.
  - Next state: ACC2 if crossing, else RESP.
- ACC2:
  - Accesses word index (W+1) modulo 2^(ADDRWIDTH-2); the top word wraps to word 0.
  - Remaining bytes are written or read.
  - Next state RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - Loads: bytes are assembled; LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend.
  - Stores: load_data=0.
  - Next state IDLE; req_ready=0 in RESP.
- Outputs outside RESP: load_data and resp_err hold their last values; only resp_valid qualifies them.
- Latency from the accept edge to resp_valid high:
  - 2 edges for aligned or non-crossing requests.
  - 3 edges for crossing requests.
  - 1 edge for illegal requests.
- Throughput: the next request can be accepted in the cycle after RESP.
- Simultaneous events:
  - req_valid while busy is ignored; upstream holds it under stall.
  - rst has priority over every transition.
- Reset mid-operation: aborts the access.
  - A crossing store reset in ACC2 leaves its ACC1 bytes written and its ACC2 bytes unwritten.
  - No resp_valid is produced.
- Byte isolation: bytes outside the addressed ones are never modified.

Test Plan:
- SW addr=0x100 data=0xDEADBEEF, then LW 0x100 → resp_valid 2 edges after each accept; load_data=0xDEADBEEF, resp_err=0.
- With word 0x100=0x80FF7F01:
  - LB 0x103 → 0xFFFFFF80.
  - LBU 0x103 → 0x00000080.
  - LH 0x102 → 0xFFFF80FF.
  - LHU 0x100 → 0x00007F01.
- SW 0x201=0x11223344 (crossing) → 3-edge latency, stall high throughout.
  - Words 0x200/0x204 become 0x223344xx/xxxxxx11; other bytes unchanged.
  - LW 0x201 returns 0x11223344.
- SH at byte address 2^ADDRWIDTH-1 with 0xABCD → byte 0x1FFFF=0xCD and byte 0x00000=0xAB (wrap); LHU at the same address returns 0x0000ABCD.
- Illegal load funct3=011, and MemRead&&MemWrite both high → resp_valid 1 edge after accept; resp_err=1, load_data=0; no RAM byte changes.
- rst asserted in ACC2 of a crossing SW:
  - Next cycle IDLE, req_ready=1, no resp_valid.
  - First-word bytes updated, second-word bytes untouched.
  - req_valid held during the busy period is accepted only after the unit returns to IDLE.
